tmds_channel_decoder: RTL and testbench
=======================================

# tmds_channel_decoder

Receive-side counterpart of the TMDS channel encoder: takes one TMDS channel's 10-bit parallel symbols from the IDES10 deserializer and finds the correct word alignment. It recovers 8-bit video data, 2-bit control data and the data-enable, and drives a bit-slip pulse back to the deserializer until control tokens decode cleanly. One instance sits per channel (blue carries hSync/vSync in cd) in the HDMI input path, clocked by the recovered pixel clock.

## Interface
- CTRL_RUN, 8: consecutive control tokens required to declare lock.
- SEARCH_WINDOW, 2048: cycles without a qualifying token run before slipping (SEARCH) or dropping lock (LOCKED); must exceed one line (800).
- SLIP_HOLD, 16: cycles ignored after each bitslip pulse while IDES10 re-aligns.
- clk  in  1  pixel clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- tmds_in  in  10  deserialized symbol; bit 0 is the first bit on the wire.
- vd  out  8  decoded video data.
- cd  out  2  decoded control data, {vSync, hSync} on blue.
- vde  out  1  1 = vd valid this cycle (data period).
- locked  out  1  word alignment established.
- bitslip  out  1  one-cycle pulse to IDES10 CALIB.
- slip_count  out  8  saturating count of bitslip pulses (see Configuration).
- relock_count  out  8  saturating count of LOCKED->SEARCH transitions (see Configuration).

## Operation
- Stage 1 registers tmds_in and classifies it as a control token or a data symbol.
- Control tokens: 1101010100->00, 0010101011->01, 0101010100->10, 1010101011->11. Any other word is a data symbol.
- Data decode: q = tmds[9] ? ~tmds[7:0] : tmds[7:0]. d[0] = q[0]. For i=1..7, d[i] = q[i]^q[i-1] when tmds[8]=1, else ~(q[i]^q[i-1]).
- Outputs when locked:
  - Control symbol: vde=0, vd=0, cd=token value.
  - Data symbol: vde=1, vd=d, cd holds its last value.
- Outputs when not locked: vde=0, vd=0, cd=0.
- run counter: counts consecutive control tokens, saturates at CTRL_RUN, clears on any data symbol.
- timer: counts up; cleared on every FSM transition and, in LOCKED, on every control token.
- FSM:
  - SEARCH: if run reaches CTRL_RUN, go to LOCKED. Otherwise, when timer reaches SEARCH_WINDOW-1, go to SLIP.
  - SLIP: bitslip=1 for exactly one cycle, then go to HOLD.
  - HOLD: clear run; ignore input for SLIP_HOLD cycles, then go to SEARCH.
  - LOCKED: when timer reaches SEARCH_WINDOW-1, go to SEARCH; relock_count increments.
- Data symbols in LOCKED never break lock; only control-token starvation does.
- Simultaneous events: in SEARCH, lock qualification beats timer expiry in the same cycle. Saturated counters hold at 255.

## Timing
- Reset: all outputs 0, FSM in SEARCH, run/timer/counters 0. Reset asserted mid-operation takes effect immediately and clears everything, including a bitslip in flight.
- Latency: a symbol sampled at edge N appears on vd/cd/vde at edge N+2.
- locked rises at the same edge as the outputs for the CTRL_RUN-th consecutive token.
- locked falls at the edge the LOCKED->SEARCH transition is registered. vde is 0 from that edge on.
- Slip cadence from reset with no valid tokens: first bitslip at edge SEARCH_WINDOW+1. After that, one pulse every SEARCH_WINDOW+SLIP_HOLD+2 cycles.
- bitslip is never asserted outside SLIP and never on two consecutive cycles.

## Configuration
- TMDS_DEC_STATS_EN defined: slip_count and relock_count are live saturating 8-bit counters, cleared only by rst.
- Undefined: both ports are driven constant 0 and the counter logic is not built. Lock behaviour is identical either way.

## Test plan
- Reset: assert rst mid-stream -> all outputs 0 asynchronously; after release, SEARCH with no bitslip for SEARCH_WINDOW cycles.
- Aligned lock: 8x 10'b1101010100, then 10'h100 -> locked=1 at the 8th token's output edge with cd=00, vde=0; next cycle vde=1, vd=8'h00.
- Control decode: locked, send 1010101011 then 0010101011 -> cd=11 then 01, vde=0, two-cycle latency.
- Misalignment: control stream rotated by 3 bits, bench models IDES10 slip -> exactly 3 bitslip pulses, spaced SEARCH_WINDOW+SLIP_HOLD+2 apart; then locked=1; slip_count=3 with TMDS_DEC_STATS_EN.
- Lock loss: locked, then data symbols only for SEARCH_WINDOW cycles -> locked falls, relock_count=1; resuming tokens relocks with no slip.
- Build without TMDS_DEC_STATS_EN: rerun the misalignment case -> identical lock timing, slip_count=0, relock_count=0.

Source files
------------

// File: rtl/tmds_channel_decoder_if.sv
// tmds_channel_decoder_if: one TMDS channel's symbol input and decoded/status outputs
interface tmds_channel_decoder_if;
  logic [9:0] tmds_in;
  logic [7:0] vd;
  logic [1:0] cd;
  logic vde;
  logic locked;
  logic bitslip;
  logic [7:0] slip_count;
  logic [7:0] relock_count;
  modport master (output tmds_in, input vd, cd, vde, locked, bitslip, slip_count, relock_count);
  modport slave (input tmds_in, output vd, cd, vde, locked, bitslip, slip_count, relock_count);
endinterface

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: TMDS symbol decode with word-alignment search; TMDS_DEC_STATS_EN builds slip/relock counters
module tmds_channel_decoder #(
  parameter int CTRL_RUN = 8,
  parameter int SEARCH_WINDOW = 2048,
  parameter int SLIP_HOLD = 16
) (
  input logic clk,
  input logic rst,
  tmds_channel_decoder_if.slave bus
);
  typedef enum logic [1:0] {SEARCH, SLIP, HOLD, LOCKED} state_t;
  localparam int RW = $clog2(CTRL_RUN + 1);
  localparam int TW = $clog2((SEARCH_WINDOW > SLIP_HOLD ? SEARCH_WINDOW : SLIP_HOLD) + 1);
  state_t state, state_nx;
  logic [9:0] sym;
  logic [RW-1:0] run, run_nx, run_inc;
  logic [TW-1:0] tmr, tmr_nx;
  logic is_ctrl, lk_nx;
  logic [1:0] tok;
  logic [7:0] q, d;
  logic [7:0] vd_r;
  logic [1:0] cd_r;
  logic vde_r;
  assign is_ctrl = sym inside {10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  assign tok = sym == 10'b0010101011 ? 2'd1 : sym == 10'b0101010100 ? 2'd2 : sym == 10'b1010101011 ? 2'd3 : 2'd0;
  assign q = sym[9] ? ~sym[7:0] : sym[7:0];
  assign d = {q[7:1] ^ q[6:0] ^ {7{~sym[8]}}, q[0]};
  assign run_inc = run == RW'(CTRL_RUN) ? run : run + RW'(1);
  assign lk_nx = state_nx == LOCKED;
  // next state, control-token run and window timer; HOLD spans SLIP_HOLD+1 cycles so slips recur every SEARCH_WINDOW+SLIP_HOLD+2
  always_comb begin
    state_nx = state;
    run_nx = is_ctrl ? run_inc : '0;
    tmr_nx = tmr + TW'(1);
    case (state)
      SEARCH: state_nx = is_ctrl && run >= RW'(CTRL_RUN - 1) ? LOCKED : tmr == TW'(SEARCH_WINDOW - 1) ? SLIP : SEARCH;
      SLIP: begin
        run_nx = '0;
        state_nx = HOLD;
      end
      HOLD: begin
        run_nx = '0;
        state_nx = tmr == TW'(SLIP_HOLD) ? SEARCH : HOLD;
      end
      LOCKED: begin
        tmr_nx = is_ctrl ? '0 : tmr_nx;
        state_nx = !is_ctrl && tmr == TW'(SEARCH_WINDOW - 1) ? SEARCH : LOCKED;
      end
      default: state_nx = SEARCH;
    endcase
    tmr_nx = state_nx != state ? '0 : tmr_nx;
  end
  // symbol capture, FSM state and decoded outputs gated by the state being entered
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= SEARCH;
      sym <= '0;
      run <= '0;
      tmr <= '0;
      vd_r <= '0;
      cd_r <= '0;
      vde_r <= 1'b0;
    end else begin
      state <= state_nx;
      sym <= bus.tmds_in;
      run <= run_nx;
      tmr <= tmr_nx;
      vde_r <= lk_nx & ~is_ctrl;
      vd_r <= lk_nx & ~is_ctrl ? d : '0;
      cd_r <= !lk_nx ? '0 : is_ctrl ? tok : cd_r;
    end
  assign bus.vd = vd_r;
  assign bus.cd = cd_r;
  assign bus.vde = vde_r;
  assign bus.locked = state == LOCKED;
  assign bus.bitslip = state == SLIP;
`ifdef TMDS_DEC_STATS_EN
  logic [7:0] slips, relocks;
  // saturating counts of slip pulses and lock losses
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      slips <= '0;
      relocks <= '0;
    end else begin
      if (state == SLIP && slips != 8'hff) slips <= slips + 8'd1;
      if (state == LOCKED && state_nx == SEARCH && relocks != 8'hff) relocks <= relocks + 8'd1;
    end
  assign bus.slip_count = slips;
  assign bus.relock_count = relocks;
`else
  assign bus.slip_count = '0;
  assign bus.relock_count = '0;
`endif
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder: table vectors, random stream vs reference model, alignment/lock-loss/reset sequences
module tb_tmds_channel_decoder;
  localparam int W = 2048;
  localparam int H = 16;
  localparam int R = 8;
`ifdef TMDS_DEC_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif
  typedef struct packed {
    logic [9:0] w;
    logic [7:0] vd;
    logic [1:0] cd;
    logic vde;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int slip_mon = 0;
  logic [9:0] toks [4];
  vec_t vt [10];
  logic [9:0] prev_w;
  logic [1:0] cd_m;
  tmds_channel_decoder_if bus();
  tmds_channel_decoder #(.CTRL_RUN(R), .SEARCH_WINDOW(W), .SLIP_HOLD(H)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.bitslip) slip_mon <= slip_mon + 1;
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic int tok_val(input logic [9:0] w);
    for (int k = 0; k < 4; k++) if (w == toks[k]) return k;
    return -1;
  endfunction
  function automatic logic [7:0] dec(input logic [9:0] w);
    int q, d;
    q = w[9] ? 255 - int'(w[7:0]) : int'(w[7:0]);
    d = q ^ ((q * 2) % 256) ^ (w[8] ? 0 : 254);
    return 8'(d);
  endfunction
  function automatic logic [9:0] rot(input logic [9:0] t, input int o);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = t[(i + o) % 10];
    return r;
  endfunction
  task automatic step(input logic [9:0] w);
    bus.tmds_in = w;
    @(negedge clk);
  endtask
  task automatic lock_seq(input string tag);
    for (int k = 1; k <= R + 1; k++) begin
      step(toks[0]);
      if (k == R) chk({tag, "_pre"}, bus.locked, 0);
      if (k == R + 1) begin
        chk(tag, bus.locked, 1);
        chk({tag, "_cd"}, bus.cd, 0);
        chk({tag, "_vde"}, bus.vde, 0);
      end
    end
  endtask
  task automatic model_step(input logic [9:0] w);
    int t;
    step(w);
    t = tok_val(prev_w);
    if (t >= 0) cd_m = 2'(t);
    chk("rnd_vde", bus.vde, t < 0);
    chk("rnd_vd", bus.vd, t < 0 ? dec(prev_w) : 8'h00);
    chk("rnd_cd", bus.cd, cd_m);
    chk("rnd_locked", bus.locked, 1);
    prev_w = w;
  endtask
  initial begin
    int snap, nslip, lock_at, o, found;
    int slip_t [4];
    logic [9:0] w;
    toks[0] = 10'b1101010100;
    toks[1] = 10'b0010101011;
    toks[2] = 10'b0101010100;
    toks[3] = 10'b1010101011;
    vt[0] = '{10'h2AB, 8'h00, 2'd3, 1'b0};
    vt[1] = '{10'h100, 8'h00, 2'd3, 1'b1};
    vt[2] = '{10'h0FF, 8'hFF, 2'd3, 1'b1};
    vt[3] = '{10'h0AB, 8'h00, 2'd1, 1'b0};
    vt[4] = '{10'h1AA, 8'hFE, 2'd1, 1'b1};
    vt[5] = '{10'h2AA, 8'h01, 2'd1, 1'b1};
    vt[6] = '{10'h154, 8'h00, 2'd2, 1'b0};
    vt[7] = '{10'h155, 8'hFF, 2'd2, 1'b1};
    vt[8] = '{10'h3FF, 8'h00, 2'd2, 1'b1};
    vt[9] = '{10'h354, 8'h00, 2'd0, 1'b0};
    bus.tmds_in = 10'h000;
    repeat (3) @(negedge clk);
    chk("rst_vd", bus.vd, 0);
    chk("rst_cd", bus.cd, 0);
    chk("rst_vde", bus.vde, 0);
    chk("rst_locked", bus.locked, 0);
    chk("rst_bitslip", bus.bitslip, 0);
    chk("rst_slip_count", bus.slip_count, 0);
    chk("rst_relock_count", bus.relock_count, 0);
    rst = 1'b0;
    lock_seq("lock");
    step(10'h100);
    chk("lock_9th_vde", bus.vde, 0);
    step(10'h100);
    chk("first_data_vde", bus.vde, 1);
    chk("first_data_vd", bus.vd, 8'h00);
    for (int i = 0; i <= 10; i++) begin
      step(i < 10 ? vt[i].w : 10'h354);
      if (i > 0) begin
        chk($sformatf("vec%0d_vd", i - 1), bus.vd, vt[i-1].vd);
        chk($sformatf("vec%0d_cd", i - 1), bus.cd, vt[i-1].cd);
        chk($sformatf("vec%0d_vde", i - 1), bus.vde, vt[i-1].vde);
      end
    end
    prev_w = 10'h354;
    cd_m = 2'd0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) w = toks[$urandom_range(0, 3)];
      else begin
        w = 10'($urandom);
        while (tok_val(w) >= 0) w = 10'($urandom);
      end
      model_step(w);
    end
    snap = slip_mon;
    step(toks[0]);
    for (int k = 1; k <= W + 1; k++) begin
      step(10'h100);
      if (k == W) begin
        chk("loss_hold", bus.locked, 1);
        chk("loss_vde_pre", bus.vde, 1);
      end
      if (k == W + 1) begin
        chk("loss_fall", bus.locked, 0);
        chk("loss_vde", bus.vde, 0);
        chk("relock_count", bus.relock_count, STATS ? 1 : 0);
      end
    end
    lock_seq("relock");
    chk("relock_no_slip", slip_mon, snap);
    step(10'h1AA);
    step(10'h1AA);
    chk("pre_rst_vde", bus.vde, 1);
    chk("pre_rst_vd", bus.vd, 8'hFE);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_vde", bus.vde, 0);
    chk("async_rst_vd", bus.vd, 0);
    chk("async_rst_locked", bus.locked, 0);
    chk("async_rst_relock", bus.relock_count, 0);
    @(negedge clk);
    rst = 1'b0;
    o = 3;
    nslip = 0;
    lock_at = -1;
    slip_t = '{0, 0, 0, 0};
    for (int j = 1; j <= 4 * (W + H + 2) && lock_at < 0; j++) begin
      step(rot(toks[0], o));
      if (bus.bitslip) begin
        if (nslip < 4) slip_t[nslip] = j;
        nslip++;
        o = (o + 9) % 10;
      end
      if (bus.locked) lock_at = j;
    end
    chk("misalign_slips", nslip, 3);
    chk("first_slip_edge", slip_t[0] + 1, W + 1);
    chk("slip_gap1", slip_t[1] - slip_t[0], W + H + 2);
    chk("slip_gap2", slip_t[2] - slip_t[1], W + H + 2);
    chk("misalign_locked", bus.locked, 1);
    chk("misalign_slip_count", bus.slip_count, STATS ? 3 : 0);
    chk("misalign_relock_count", bus.relock_count, 0);
    snap = slip_mon;
    repeat (50) step(toks[0]);
    chk("aligned_stays_locked", bus.locked, 1);
    chk("aligned_no_slip", slip_mon, snap);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    found = 0;
    for (int j = 1; j <= W + 10 && found == 0; j++) begin
      step(10'h000);
      if (bus.bitslip) found = 1;
    end
    chk("inflight_slip_seen", found, 1);
    #1 rst = 1'b1;
    #1;
    chk("inflight_rst_bitslip", bus.bitslip, 0);
    chk("inflight_rst_slip_count", bus.slip_count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
